// File: rtl/sub_pix_pkg.sv
// rtl/sub_pix_pkg.sv - shared widths, lane slice helper and FSM states for sub_pix_out_packer
package sub_pix_pkg;

  localparam int L     = 4;
  localparam int IN_W  = 14;
  localparam int DROP  = 2;
  localparam int OUT_W = IN_W - DROP;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Lane j of a packed interpolant bus, lane 0 in the LSBs
  function automatic logic [IN_W-1:0] lane_slice(input logic [L*IN_W-1:0] bus, input int lane);
    return bus[lane*IN_W +: IN_W];
  endfunction

endpackage

// File: rtl/sub_pix_sync_fifo.sv
// rtl/sub_pix_sync_fifo.sv - synchronous FIFO with MSB-extended pointers for full/empty
module sub_pix_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 49
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read in the same cycle frees the slot, so a write while full is still taken
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head is forced to zero when empty so the output is clean after reset
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next storage contents and pointer values
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sub_pix_out_packer.sv
// rtl/sub_pix_out_packer.sv - selects, rounds and saturates 4 interpolant lanes, frames them into lines
// Optional build macro SUB_PIX_SAT_STATS_EN adds the sat_cnt saturation-event counter.
module sub_pix_out_packer
  import sub_pix_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LINE_BEATS = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_v,
  input  logic [L*IN_W-1:0]  in_a,
  input  logic [L*IN_W-1:0]  in_b,
  input  logic               sel_b,
  input  logic               line_start,
  output logic               in_rdy,
  output logic [L*OUT_W-1:0] out_data,
  output logic               out_v,
  input  logic               out_rdy,
  output logic               out_eol,
  output logic               overflow,
  output logic               busy
`ifdef SUB_PIX_SAT_STATS_EN
  ,
  output logic [15:0]        sat_cnt
`endif
);

  localparam int               FW         = 1 + L*OUT_W;
  localparam int               RND_HALF_I = 1 << (DROP - 1);
  localparam logic [IN_W:0]    RND_HALF   = RND_HALF_I[IN_W:0];
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stage_v_q, stage_v_d;
  logic               stage_eol_q, stage_eol_d;
  logic [L*OUT_W-1:0] stage_data_q, stage_data_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;

  logic [L*OUT_W-1:0] rnd_data;
  logic [IN_W:0]      lane_r;
  logic               beat;
  logic               fifo_full, fifo_empty, fifo_rd;
  logic [FW-1:0]      fifo_rdata;
`ifdef SUB_PIX_SAT_STATS_EN
  logic [2:0]         sat_lanes;
`endif

  // Beats are only taken while a line is open
  assign beat    = in_v && (state_q == ACTIVE);
  assign fifo_rd = !fifo_empty && out_rdy;

  // Per-lane select, round half-up on IN_W+1 bits, saturate when the carry reaches bit IN_W
  always_comb begin
    rnd_data = '0;
    lane_r   = '0;
`ifdef SUB_PIX_SAT_STATS_EN
    sat_lanes = '0;
`endif
    for (int j = 0; j < L; j++) begin
      lane_r = {1'b0, (sel_b ? lane_slice(in_b, j) : lane_slice(in_a, j))} + RND_HALF;
      if (lane_r[IN_W]) begin
        rnd_data[j*OUT_W +: OUT_W] = '1;
`ifdef SUB_PIX_SAT_STATS_EN
        sat_lanes = sat_lanes + 3'd1;
`endif
      end else begin
        rnd_data[j*OUT_W +: OUT_W] = OUT_W'(lane_r >> DROP);
      end
    end
  end

  // Line FSM, beat counter, rounding stage and sticky overflow next-state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_v_d    = beat;
    stage_eol_d  = 1'b0;
    stage_data_d = beat ? rnd_data : stage_data_q;
    // A staged beat that meets a full FIFO with no read is lost but still counted
    overflow_d   = overflow_q | (stage_v_q & fifo_full & ~fifo_rd);
    case (state_q)
      IDLE: begin
        if (line_start) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (in_v) begin
          if (cnt_q == LAST_BEAT) begin
            stage_eol_d = 1'b1;
            state_d     = DRAIN;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !stage_v_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and stage registers; reset discards any in-flight beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stage_v_q    <= 1'b0;
      stage_eol_q  <= 1'b0;
      stage_data_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_v_q    <= stage_v_d;
      stage_eol_q  <= stage_eol_d;
      stage_data_q <= stage_data_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  sub_pix_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (stage_v_q),
    .wr_data ({stage_eol_q, stage_data_q}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_v    = !fifo_empty;
  assign out_data = fifo_rdata[L*OUT_W-1:0];
  assign out_eol  = fifo_rdata[FW-1];
  assign in_rdy   = !fifo_full;
  assign overflow = overflow_q;
  assign busy     = busy_q;

`ifdef SUB_PIX_SAT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum;

  // Saturation events per line, clamped at all-ones, cleared when a line is armed
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_lanes);
    sat_cnt_d = sat_cnt_q;
    if ((state_q == IDLE) && line_start) begin
      sat_cnt_d = '0;
    end else if (beat) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  // Saturation counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sub_pix_out_packer.sv
// tb/tb_sub_pix_out_packer.sv - self-checking bench for sub_pix_out_packer
module tb_sub_pix_out_packer;

  localparam int LB    = 12;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, in_v, sel_b, line_start, out_rdy;
  logic [55:0] in_a, in_b;
  logic        in_rdy, out_v, out_eol, overflow, busy;
  logic [47:0] out_data;
`ifdef SUB_PIX_SAT_STATS_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  sub_pix_out_packer #(.DEPTH(DEPTH), .LINE_BEATS(LB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_v       (in_v),
    .in_a       (in_a),
    .in_b       (in_b),
    .sel_b      (sel_b),
    .line_start (line_start),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_v      (out_v),
    .out_rdy    (out_rdy),
    .out_eol    (out_eol),
    .overflow   (overflow),
    .busy       (busy)
`ifdef SUB_PIX_SAT_STATS_EN
    , .sat_cnt  (sat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic eol; logic [47:0] data; } beat_t;
  typedef struct { logic [55:0] a; logic [55:0] b; logic s; logic [47:0] e; } vec_t;

  // Reference model: FIFO contents as a queue, one pending rounded beat, line bookkeeping
  beat_t mq[$];
  beat_t m_stage;
  bit    m_stage_v = 0, m_ovf = 0, m_busy = 0, m_open = 0;
  int    m_beats = 0;

  vec_t        tv[6];
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] pin(input logic [13:0] l0, input logic [13:0] l1,
                                      input logic [13:0] l2, input logic [13:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [47:0] pout(input logic [11:0] l0, input logic [11:0] l1,
                                       input logic [11:0] l2, input logic [11:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Rounded pixel = min((v + 2) / 4, 4095) per lane
  function automatic logic [47:0] expect_pix(input logic [55:0] a, input logic [55:0] b, input logic s);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int v;
      int o;
      v = s ? int'(b[j*14 +: 14]) : int'(a[j*14 +: 14]);
      o = (v + 2) / 4;
      if (o > 4095) o = 4095;
      r[j*12 +: 12] = o[11:0];
    end
    return r;
  endfunction

  task automatic model_edge();
    int pre_size;
    bit rd, pre_empty, pre_stage, pre_open, pre_busy, bt;
    if (!reset) begin
      mq.delete();
      m_stage_v = 0; m_ovf = 0; m_busy = 0; m_open = 0; m_beats = 0;
      return;
    end
    pre_size  = mq.size();
    pre_empty = (pre_size == 0);
    pre_stage = m_stage_v;
    pre_open  = m_open;
    pre_busy  = m_busy;
    rd        = !pre_empty && out_rdy;
    if (rd) void'(mq.pop_front());
    if (pre_stage) begin
      if (pre_size < DEPTH || rd) mq.push_back(m_stage);
      else m_ovf = 1;
    end
    bt = in_v && pre_open;
    m_stage_v = bt;
    if (bt) begin
      m_beats++;
      m_stage.eol  = (m_beats == LB);
      m_stage.data = expect_pix(in_a, in_b, sel_b);
      if (m_beats == LB) m_open = 0;
    end
    if (!pre_busy) begin
      if (line_start) begin m_busy = 1; m_open = 1; m_beats = 0; end
    end else if (!pre_open && pre_empty && !pre_stage) begin
      m_busy = 0;
    end
  endtask

  task automatic check_outs();
    beat_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("out_v", out_v, mq.size() > 0);
    chk("out_data", out_data, h.data);
    chk("out_eol", out_eol, h.eol);
    chk("in_rdy", in_rdy, mq.size() < DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic send(input logic [55:0] a, input logic [55:0] b, input logic s);
    in_a = a; in_b = b; sel_b = s; in_v = 1'b1;
    tick();
    in_v = 1'b0;
  endtask

  task automatic start_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    out_rdy = 1'b1;
    while (busy && n < 60) begin tick(); n++; end
    chk("wait_idle", busy, 0);
  endtask

  function automatic logic [55:0] rnd56();
    return 56'({$urandom(), $urandom()});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, nbeat, eol_at, got;
    logic [55:0] ra, rb;
    logic        rs;

    tv[0] = '{pin(14'h0006, 14'h0003, 14'h1000, 14'h3FFF), pin(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), 1'b0,
              pout(12'h002, 12'h001, 12'h400, 12'hFFF)};
    tv[1] = '{pin(14'h0005, 14'h0000, 14'h0002, 14'h0001), pin(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), 1'b0,
              pout(12'h001, 12'h000, 12'h001, 12'h000)};
    tv[2] = '{pin(14'h3FFE, 14'h3FFD, 14'h3FFC, 14'h3FF9), pin(14'h0000, 14'h0000, 14'h0000, 14'h0000), 1'b0,
              pout(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE)};
    tv[3] = '{pin(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), pin(14'h0000, 14'h0001, 14'h0002, 14'h0006), 1'b1,
              pout(12'h000, 12'h000, 12'h001, 12'h002)};
    tv[4] = '{pin(14'h0000, 14'h0000, 14'h0000, 14'h0000), pin(14'h2AAA, 14'h1555, 14'h0FFF, 14'h3FFF), 1'b1,
              pout(12'hAAB, 12'h555, 12'h400, 12'hFFF)};
    tv[5] = '{pin(14'h0001, 14'h0002, 14'h0003, 14'h0004), pin(14'h2000, 14'h2000, 14'h2000, 14'h2000), 1'b0,
              pout(12'h000, 12'h001, 12'h001, 12'h001)};

    reset = 1'b0; in_v = 1'b0; sel_b = 1'b0; line_start = 1'b0; out_rdy = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    chk("rst out_v", out_v, 0);
    chk("rst out_eol", out_eol, 0);
    chk("rst overflow", overflow, 0);
    chk("rst busy", busy, 0);
    chk("rst in_rdy", in_rdy, 1);
    chk("rst out_data", out_data, 0);
    reset = 1'b1;
    tick();

    // Table vectors framed as one line of LB beats; EOL only on the last
    start_line();
    for (int i = 0; i < LB; i++) begin
      send(tv[i % 6].a, tv[i % 6].b, tv[i % 6].s);
      n = 0;
      while (!out_v && n < 6) begin tick(); n++; end
      chk("tv latency", n, 1);
      chk("tv data", out_data, tv[i % 6].e);
      chk("tv eol", out_eol, i == LB - 1);
      tick();
      if (i == LB - 1) begin
        chk("busy on last read", busy, 1);
        tick();
        chk("busy drop after last read", busy, 0);
      end
    end
    wait_idle();

    // Fill to DEPTH, then full-plus-read, then drops while full
    start_line();
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = rnd56(); rb = rnd56(); rs = 1'($urandom_range(0, 1));
      exp_q.push_back(expect_pix(ra, rb, rs));
      send(ra, rb, rs);
    end
    tick();
    chk("full in_rdy", in_rdy, 0);
    chk("full no overflow", overflow, 0);
    ra = rnd56(); rb = rnd56(); rs = 1'($urandom_range(0, 1));
    send(ra, rb, rs);
    chk("head before full read", out_data, exp_q[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(expect_pix(ra, rb, rs));
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("full+read overflow", overflow, 0);
    chk("full+read in_rdy", in_rdy, 0);
    for (int i = 0; i < 3; i++) send(rnd56(), rnd56(), 1'($urandom_range(0, 1)));
    tick();
    chk("drop overflow", overflow, 1);
    chk("drop busy", busy, 1);
    out_rdy = 1'b1;
    n = 0; got = 0;
    while (exp_q.size() > 0 && n < 40) begin
      if (out_v) begin
        chk("drain data", out_data, exp_q.pop_front());
        chk("drain eol", out_eol, 0);
        got++;
      end
      tick();
      n++;
    end
    chk("drain count", got, 8);
    wait_idle();
    chk("overflow sticky", overflow, 1);

    // Reset mid-line, then a fresh line counts from zero
    start_line();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd56(), rnd56(), 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst out_v", out_v, 0);
    chk("midrst busy", busy, 0);
    chk("midrst overflow", overflow, 0);
    tick();
    out_rdy = 1'b1;
    start_line();
    nbeat = 0; eol_at = 0;
    for (int i = 0; i < LB; i++) begin
      send(rnd56(), rnd56(), 1'($urandom_range(0, 1)));
      if (out_v) begin nbeat++; if (out_eol) eol_at = nbeat; end
    end
    n = 0;
    while (busy && n < 20) begin
      tick();
      if (out_v) begin nbeat++; if (out_eol) eol_at = nbeat; end
      n++;
    end
    chk("restart beats", nbeat, LB);
    chk("restart eol pos", eol_at, LB);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_v  = ($urandom_range(0, 3) != 0);
      in_a  = rnd56();
      in_b  = rnd56();
      if ($urandom_range(0, 3) == 0) in_a[13:0] = 14'(14'h3FFF - 14'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) in_b[27:14] = 14'(14'h3FFF - 14'($urandom_range(0, 3)));
      sel_b = 1'($urandom_range(0, 1));
      line_start = ($urandom_range(0, 7) == 0);
      out_rdy = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1; in_v = 1'b0; line_start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
